hvsync_generator: RTL and testbench

HVSYNC_GENERATOR -- requirements
Module: hvsync_generator

---
 rtl/hvsync_generator.sv | 71 +++++++
 tb/tb_hvsync_generator.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/hvsync_generator.sv
// rtl/hvsync_generator.sv - raster timing generator: beam position, registered syncs, display enable
// The beam counters wrap per line/frame; syncs are registered from the current counters, so they lag by one clock.
module hvsync_generator #(
    parameter int H_DISPLAY = 256,
    parameter int H_BACK    = 23,
    parameter int H_FRONT   = 7,
    parameter int H_SYNC    = 23,
    parameter int V_DISPLAY = 240,
    parameter int V_TOP     = 5,
    parameter int V_BOTTOM  = 14,
    parameter int V_SYNC    = 3
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [8:0] hpos,
    output logic [8:0] vpos
);

    localparam logic [8:0] H_DISP_W     = 9'(H_DISPLAY);
    localparam logic [8:0] H_SYNC_START = 9'(H_DISPLAY + H_FRONT);
    localparam logic [8:0] H_SYNC_END   = 9'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [8:0] H_MAX        = 9'(H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1);
    localparam logic [8:0] V_DISP_W     = 9'(V_DISPLAY);
    localparam logic [8:0] V_SYNC_START = 9'(V_DISPLAY + V_BOTTOM);
    localparam logic [8:0] V_SYNC_END   = 9'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
    localparam logic [8:0] V_MAX        = 9'(V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1);

    logic [8:0] hpos_q, hpos_d;
    logic [8:0] vpos_q, vpos_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       line_end;
    logic       frame_end;

    always_comb begin
        line_end  = (hpos_q == H_MAX);
        frame_end = (vpos_q == V_MAX);
        hpos_d    = line_end ? 9'd0 : hpos_q + 9'd1;
        vpos_d    = vpos_q;
        if (line_end) begin
            vpos_d = frame_end ? 9'd0 : vpos_q + 9'd1;
        end
        // Decoded from the present position, so the registered syncs trail the counters by one clock.
        hsync_d = (hpos_q >= H_SYNC_START) && (hpos_q <= H_SYNC_END);
        vsync_d = (vpos_q >= V_SYNC_START) && (vpos_q <= V_SYNC_END);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hpos_q  <= 9'd0;
            vpos_q  <= 9'd0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign hpos       = hpos_q;
    assign vpos       = vpos_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign display_on = (hpos_q < H_DISP_W) && (vpos_q < V_DISP_W);

endmodule

// File: tb/tb_hvsync_generator.sv
// tb/tb_hvsync_generator.sv - scoreboard bench for hvsync_generator (default, mid-frame reset, small-geometry instances)
module tb_hvsync_generator;

    typedef struct {
        int tag;
        int dut;
        int h;
        int v;
        bit hs;
        bit vs;
        bit de;
    } exp_t;

    exp_t q[$];
    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic       hs[3];
    logic       vs[3];
    logic       de[3];
    logic [8:0] hp[3];
    logic [8:0] vp[3];
    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    int hs_cnt = 0;
    int vs_cnt = 0;
    int de_cnt = 0;
    event sample_ev;

    always #5 clk = ~clk;

    hvsync_generator u_dut0 (.clk(clk), .reset(rst_a), .hsync(hs[0]), .vsync(vs[0]),
        .display_on(de[0]), .hpos(hp[0]), .vpos(vp[0]));
    hvsync_generator u_dut1 (.clk(clk), .reset(rst_b), .hsync(hs[1]), .vsync(vs[1]),
        .display_on(de[1]), .hpos(hp[1]), .vpos(vp[1]));
    hvsync_generator #(.H_DISPLAY(8), .H_BACK(1), .H_FRONT(1), .H_SYNC(2),
        .V_DISPLAY(4), .V_TOP(1), .V_BOTTOM(1), .V_SYNC(1)) u_dut2 (
        .clk(clk), .reset(rst_a), .hsync(hs[2]), .vsync(vs[2]),
        .display_on(de[2]), .hpos(hp[2]), .vpos(vp[2]));

    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) cyc = 0;
        else        cyc = cyc + 1;
    end

    task automatic expect_at(input int tag, input int dut, input int h, input int v,
                             input bit hsv, input bit vsv, input bit dev);
        exp_t e;
        e.tag = tag; e.dut = dut; e.h = h; e.v = v; e.hs = hsv; e.vs = vsv; e.de = dev;
        q.push_back(e);
    endtask

    task automatic check_front();
        exp_t e;
        int d;
        e = q.pop_front();
        d = e.dut;
        n_total++;
        if (e.tag >= 0 && e.tag < cyc) begin
            $display("FAIL missed_sample dut%0d tag %0d: got cycle %0d", d, e.tag, cyc);
        end else if (int'(hp[d]) != e.h || int'(vp[d]) != e.v || hs[d] != e.hs ||
                     vs[d] != e.vs || de[d] != e.de) begin
            $display("FAIL pos dut%0d tag %0d: got h=%0d v=%0d hs=%0b vs=%0b de=%0b want h=%0d v=%0d hs=%0b vs=%0b de=%0b",
                     d, e.tag, hp[d], vp[d], hs[d], vs[d], de[d], e.h, e.v, e.hs, e.vs, e.de);
        end else begin
            n_pass++;
        end
    endtask

    always @(negedge clk) begin
        if (rst_a && cyc >= 1 && cyc <= 80958) begin
            hs_cnt += int'(hs[0]);
            vs_cnt += int'(vs[0]);
            de_cnt += int'(de[0]);
        end
        while (q.size() > 0 && q[0].tag >= 0 && q[0].tag <= cyc) check_front();
    end

    always @(sample_ev) begin
        if (q.size() > 0 && q[0].tag < 0) check_front();
    end

    task automatic agg(input string name, input int got, input int want);
        n_total++;
        if (got != want) $display("FAIL %s: got %0d want %0d", name, got, want);
        else n_pass++;
    endtask

    initial begin
        expect_at(0, 0, 0, 0, 0, 0, 1);
        expect_at(0, 2, 0, 0, 0, 0, 1);
        expect_at(1, 0, 1, 0, 0, 0, 1);
        expect_at(7, 2, 7, 0, 0, 0, 1);
        expect_at(8, 2, 8, 0, 0, 0, 0);
        expect_at(9, 2, 9, 0, 0, 0, 0);
        expect_at(10, 2, 10, 0, 1, 0, 0);
        expect_at(11, 2, 11, 0, 1, 0, 0);
        expect_at(12, 2, 0, 1, 0, 0, 1);
        expect_at(60, 2, 0, 5, 0, 0, 0);
        expect_at(61, 2, 1, 5, 0, 1, 0);
        expect_at(72, 2, 0, 6, 0, 1, 0);
        expect_at(73, 2, 1, 6, 0, 0, 0);
        expect_at(84, 2, 0, 0, 0, 0, 1);
        expect_at(255, 0, 255, 0, 0, 0, 1);
        expect_at(256, 0, 256, 0, 0, 0, 0);
        expect_at(263, 0, 263, 0, 0, 0, 0);
        expect_at(264, 0, 264, 0, 1, 0, 0);
        expect_at(286, 0, 286, 0, 1, 0, 0);
        expect_at(287, 0, 287, 0, 0, 0, 0);
        expect_at(308, 0, 308, 0, 0, 0, 0);
        expect_at(309, 0, 0, 1, 0, 0, 1);
        expect_at(31050, 1, 150, 100, 0, 0, 1);
        expect_at(-1, 1, 0, 0, 0, 0, 1);
        expect_at(31051, 1, 0, 0, 0, 0, 1);
        expect_at(31053, 1, 1, 0, 0, 0, 1);
        expect_at(31316, 1, 264, 0, 1, 0, 0);
        expect_at(31361, 1, 0, 1, 0, 0, 1);
        expect_at(74160, 0, 0, 240, 0, 0, 0);
        expect_at(78486, 0, 0, 254, 0, 0, 0);
        expect_at(78487, 0, 1, 254, 0, 1, 0);
        expect_at(79413, 0, 0, 257, 0, 1, 0);
        expect_at(79414, 0, 1, 257, 0, 0, 0);
        expect_at(80957, 0, 308, 261, 0, 0, 0);
        expect_at(80958, 0, 0, 0, 0, 0, 1);

        #22;
        rst_a = 1'b1;
        rst_b = 1'b1;
        while (cyc < 31050) @(negedge clk);
        #1 rst_b = 1'b0;
        #1 -> sample_ev;
        while (cyc < 31052) @(negedge clk);
        #1 rst_b = 1'b1;
        while (cyc < 80960) @(negedge clk);
        #1;
        agg("hsync_cycles_per_frame", hs_cnt, 6026);
        agg("vsync_cycles_per_frame", vs_cnt, 927);
        agg("display_cycles_per_frame", de_cnt, 61440);
        agg("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
